fir_output_requant: RTL and testbench

Receive-side stage for the FIR filter output stream. Accepts the filter's wide, gain-extended samples (`valid_in`/`data_in`, no backpressure toward the filter), rounds and saturates them back to DATA_W, and buffers them in a FIFO. Downstream consumers read through a valid/ready handshake. It sits directly after the filter, replacing the bench-style "sample whenever valid" capture with a flow-controlled sink.

---
 rtl/fir_output_requant_if.sv | 31 +++
 rtl/fir_output_requant.sv | 135 +++++++++++++
 tb/tb_fir_output_requant.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_requant_if.sv
// Stream bundle for fir_output_requant: unthrottled wide input strobe plus
// valid/ready requantized output. The slave modport is the requant stage.
interface fir_output_requant_if #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 4
);
    logic                       valid_in;
    logic [DATA_W+GAIN_W-1:0]   data_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_sat;

    modport master (
        output valid_in,
        output data_in,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/fir_output_requant.sv
// Rounds/saturates wide FIR output samples to DATA_W and buffers them in a FIFO
// with a valid/ready read side. Saturation/drop counters exist only with REQUANT_STATS_EN.
module fir_output_requant #(
    parameter int DATA_W     = 16,
    parameter int GAIN_W     = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_output_requant_if.slave  bus,
    output logic                 overflow,
    input  logic                 clr_stats,
    output logic [15:0]          sat_count,
    output logic [15:0]          drop_count
);

    localparam int IW = DATA_W + GAIN_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = IW - DATA_W + 2;

    // Half an LSB of the post-shift result; zero when SHIFT is 0.
    localparam logic signed [IW:0] RND = ((IW+1)'(1) << SHIFT) >> 1;

    logic signed [IW:0]    rnd_sum;
    logic signed [IW:0]    shifted;
    logic [HW-1:0]         hi_bits;
    logic                  q_sat;
    logic [DATA_W-1:0]     q_data;

    logic                  r1_valid;
    logic [DATA_W-1:0]     r1_data;
    logic                  r1_sat;

    logic [DATA_W:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_W:0]       head;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    always_comb begin
        rnd_sum = $signed({bus.data_in[IW-1], bus.data_in}) + RND;
        shifted = rnd_sum >>> SHIFT;
        hi_bits = shifted[IW:DATA_W-1];
        // In range only if every bit above the output sign matches it.
        q_sat   = !((&hi_bits) || !(|hi_bits));
        if (q_sat)
            q_data = {shifted[IW], {(DATA_W-1){~shifted[IW]}}};
        else
            q_data = shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_data  <= '0;
            r1_sat   <= 1'b0;
        end else begin
            r1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r1_data <= q_data;
                r1_sat  <= q_sat;
            end
        end
    end

    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = bus.out_valid && bus.out_ready;
    assign wr_en = r1_valid && (!full || pop);
    assign drop  = r1_valid && !wr_en;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {r1_sat, r1_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is masked when empty so stale RAM contents never reach the outputs.
    assign head          = mem[rd_ptr];
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? head[DATA_W-1:0] : '0;
    assign bus.out_sat   = bus.out_valid ? head[DATA_W] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (clr_stats)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

`ifdef REQUANT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count  <= '0;
            drop_count <= '0;
        end else if (clr_stats) begin
            sat_count  <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en && r1_sat && (sat_count != 16'hFFFF))
                sat_count <= sat_count + 16'd1;
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign sat_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fir_output_requant.sv
// Scoreboard bench for fir_output_requant: directed samples push expected
// heads into a queue, a negedge monitor pops and compares on each handshake.
module tb_fir_output_requant;

    localparam int DW = 16;
    localparam int GW = 4;
    localparam int IW = DW + GW;
`ifdef REQUANT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_stats = 1'b0;
    logic        overflow;
    logic [15:0] sat_count;
    logic [15:0] drop_count;

    fir_output_requant_if #(.DATA_W(DW), .GAIN_W(GW)) bus ();

    fir_output_requant #(
        .DATA_W(DW), .GAIN_W(GW), .SHIFT(4), .FIFO_DEPTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .overflow   (overflow),
        .clr_stats  (clr_stats),
        .sat_count  (sat_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] sb [$];

    function automatic int stat(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [IW-1:0] d, input bit keep, input logic [15:0] e, input bit es);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        if (keep)
            sb.push_back({es, e});
        step(1);
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"},   32'(bus.out_data),  32'd0);
        chk({tag, "_out_sat"},    32'(bus.out_sat),   32'd0);
        chk({tag, "_overflow"},   32'(overflow),      32'd0);
        chk({tag, "_sat_count"},  32'(sat_count),     32'd0);
        chk({tag, "_drop_count"}, 32'(drop_count),    32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got data 0x%0h with no expected entry at %0t",
                         bus.out_data, $time);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(e[15:0]));
                chk("sb_sat",  32'(bus.out_sat),  32'(e[16]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        step(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(2);

        // Rounding and two-cycle latency into an empty FIFO.
        put(20'd100, 1'b1, 16'd6, 1'b0);
        idle();
        chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data",  32'(bus.out_data),  32'd6);
        chk("lat_sat",   32'(bus.out_sat),   32'd0);
        bus.out_ready = 1'b1;
        step(2);
        chk("lat_drained", 32'(sb.size()), 32'd0);

        put(20'hFFFE8, 1'b1, 16'hFFFF, 1'b0);   // -24 -> -1
        put(20'd8,     1'b1, 16'd1,    1'b0);   // exact half rounds up
        put(20'd7,     1'b1, 16'd0,    1'b0);
        put(20'hFFFF8, 1'b1, 16'd0,    1'b0);   // -8 -> 0
        put(20'hFFFF7, 1'b1, 16'hFFFF, 1'b0);   // -9 -> -1
        put(20'h7FFF0, 1'b1, 16'h7FFF, 1'b0);   // largest value not clamped
        put(20'h7FFFF, 1'b1, 16'h7FFF, 1'b1);
        put(20'h80000, 1'b1, 16'h8000, 1'b0);
        idle();
        step(4);
        chk("round_drained",  32'(sb.size()),    32'd0);
        chk("round_sat_cnt",  32'(sat_count),    32'(stat(1)));
        chk("round_drop_cnt", 32'(drop_count),   32'd0);
        chk("round_overflow", 32'(overflow),     32'd0);

        // Backpressure: ten samples into eight entries.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++)
            put(20'(i * 16), (i <= 8), 16'(i), 1'b0);
        idle();
        step(2);
        chk("bp_overflow",  32'(overflow),      32'd1);
        chk("bp_drop_cnt",  32'(drop_count),    32'(stat(2)));
        chk("bp_valid",     32'(bus.out_valid), 32'd1);
        chk("bp_head",      32'(bus.out_data),  32'd1);
        step(3);
        chk("bp_head_hold", 32'(bus.out_data),  32'd1);
        bus.out_ready = 1'b1;
        step(8);
        chk("bp_drain_rate", 32'(sb.size()),     32'd0);
        chk("bp_empty",      32'(bus.out_valid), 32'd0);
        chk("bp_sat_cnt",    32'(sat_count),     32'(stat(1)));

        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        chk("clr_overflow", 32'(overflow),   32'd0);
        chk("clr_sat_cnt",  32'(sat_count),  32'd0);
        chk("clr_drop_cnt", 32'(drop_count), 32'd0);

        // Fill to full, then pop and write in the same cycle while streaming.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j == 9)
                bus.out_ready = 1'b1;
            put(20'((j + 50) * 16), 1'b1, 16'(j + 50), 1'b0);
            if (j >= 9)
                chk("fullpop_valid", 32'(bus.out_valid), 32'd1);
        end
        idle();
        step(12);
        chk("fullpop_drained",  32'(sb.size()),     32'd0);
        chk("fullpop_drop_cnt", 32'(drop_count),    32'd0);
        chk("fullpop_overflow", 32'(overflow),      32'd0);
        chk("fullpop_empty",    32'(bus.out_valid), 32'd0);

        // Clear coinciding with a drop: clear wins.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 9; j++)
            put(20'((j + 100) * 16), (j < 8), 16'(j + 100), 1'b0);
        idle();
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        chk("clrdrop_overflow", 32'(overflow),   32'd0);
        chk("clrdrop_drop_cnt", 32'(drop_count), 32'd0);
        put(20'h00010, 1'b0, 16'd0, 1'b0);
        idle();
        step(1);
        chk("drop2_overflow", 32'(overflow),   32'd1);
        chk("drop2_drop_cnt", 32'(drop_count), 32'(stat(1)));
        bus.out_ready = 1'b1;
        step(10);
        chk("drop2_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with five entries buffered.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++)
            put(20'((j + 200) * 16), 1'b1, 16'(j + 200), 1'b0);
        idle();
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        step(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        put(20'd48, 1'b1, 16'd3, 1'b0);
        idle();
        chk("post_rst_early", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data",  32'(bus.out_data),  32'd3);
        step(2);
        chk("post_rst_drained", 32'(sb.size()),     32'd0);
        chk("post_rst_empty",   32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
